// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types for the two-port ALU arbiter.
// Holds ALU select encodings, tag layout and parameter defaults.
package alu_arb_pkg;

  localparam int W_DEF     = 32;
  localparam int LAT_DEF   = 2;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_OR  = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SLL = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NEG = 4'b1000,
    ALU_SUB = 4'b1100
  } alu_sel_e;

  // One in-flight ALU op: valid bit plus owning requester.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/alu_arbiter_rsp_fifo.sv
// rsp_fifo: per-requester response buffer, DEPTH entries.
// Ports: push_i/din_i in, pop_i/valid_o/dout_o out (head).
module rsp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i)  rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i)
                     - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign valid_o = (cnt_q != '0);
  assign dout_o  = mem_q[rd_q];

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin, credit-gated sharing of one ALU
// by two requesters; req/alu/rsp handshakes, busy flag.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         Areset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_result,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cred0_q, cred0_d;
  logic [CW-1:0] cred1_q, cred1_d;
  logic [CW-1:0] post0, post1;
  logic          prio_q, prio_d;
  tag_t          tag_q [LAT];
  tag_t          tag_d;
  logic          pop0, pop1;
  logic          elig0, elig1;
  logic          gnt0, gnt1;
  logic          push0, push1;

  always_comb begin
    pop0  = rsp0_valid & rsp0_ready;
    pop1  = rsp1_valid & rsp1_ready;
    // Eligibility sees this cycle's pop, so a full
    // requester popping now may still be granted.
    post0 = cred0_q - CW'(pop0);
    post1 = cred1_q - CW'(pop1);
    elig0 = !Areset && req0_valid
            && (post0 < CW'(DEPTH));
    elig1 = !Areset && req1_valid
            && (post1 < CW'(DEPTH));
    // prio_q names the requester favoured on a tie.
    gnt0  = elig0 && (!elig1 || !prio_q);
    gnt1  = elig1 && (!elig0 || prio_q);
    cred0_d = post0 + CW'(gnt0);
    cred1_d = post1 + CW'(gnt1);
    prio_d  = prio_q;
    tag_d   = '{vld: gnt0 | gnt1, id: gnt1};
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = 4'b0000;
    unique case (1'b1)
      gnt0: begin
        prio_d  = 1'b1;
        alu_a   = req0_a;
        alu_b   = req0_b;
        alu_sel = req0_sel;
      end
      gnt1: begin
        prio_d  = 1'b0;
        alu_a   = req1_a;
        alu_b   = req1_b;
        alu_sel = req1_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Areset) begin
      cred0_q <= '0;
      cred1_q <= '0;
      prio_q  <= 1'b0;
      for (int i = 0; i < LAT; i++)
        tag_q[i] <= '0;
    end else begin
      cred0_q  <= cred0_d;
      cred1_q  <= cred1_d;
      prio_q   <= prio_d;
      tag_q[0] <= tag_d;
      for (int i = 1; i < LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign push0 = tag_q[LAT-1].vld
               & ~tag_q[LAT-1].id;
  assign push1 = tag_q[LAT-1].vld
               &  tag_q[LAT-1].id;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy = (cred0_q != '0)
              | (cred1_q != '0);

  rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_i   (Areset),
    .push_i  (push0),
    .din_i   (alu_result),
    .pop_i   (pop0),
    .valid_o (rsp0_valid),
    .dout_o  (rsp0_data)
  );

  rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_i   (Areset),
    .push_i  (push1),
    .din_i   (alu_result),
    .pop_i   (pop1),
    .valid_o (rsp1_valid),
    .dout_o  (rsp1_data)
  );

endmodule
